tree_feed_deserializer: RTL and testbench
=========================================

# tree_feed_deserializer

Serial-to-parallel front end for the pipelined adder tree. Accepts one WIDTH-bit sample per handshake and assembles LEN samples into a packed LEN*WIDTH vector in the tree's lane order (sample k in bits [WIDTH*k +: WIDTH]). It then presents the vector with a valid/ready handshake. Double-buffered (fill register plus output register) so back-to-back frames stream without bubbles; short frames terminated by `in_last` are zero-padded.

## Interface
- `WIDTH`, 16, sample width in bits (signed two's complement, passed through unmodified)
- `LEN`, 1024, lanes per frame; power of two, >= 2
- `clk`  input  1  rising-edge clock
- `reset`  input  1  synchronous, active-high reset
- `in_data`  input  WIDTH  serial sample
- `in_valid`  input  1  `in_data` valid
- `in_last`  input  1  qualifies the accepted sample as the final one of a short frame
- `in_ready`  output  1  block can accept a sample this cycle
- `out_packed`  output  LEN*WIDTH  assembled frame, lane k at [WIDTH*k +: WIDTH]
- `out_len`  output  $clog2(LEN)+1  number of written lanes in `out_packed` (1..LEN)
- `out_valid`  output  1  `out_packed`/`out_len` valid
- `out_ready`  input  1  consumer takes the frame this cycle

## Operation
- Storage: fill register (LEN*WIDTH), fill counter `cnt` (0..LEN-1), output register, `out_len` register, state register.
- States: FILL (in_ready=1) and HOLD (in_ready=0; a completed frame is waiting for the output slot).
- Input accept: `in_valid && in_ready`. The sample is written to lane `cnt`, and `cnt` increments.
- Frame completion occurs when the accepted sample has `cnt==LEN-1` or `in_last==1`. The frame length is `cnt+1`.
- Output slot is free when `!out_valid || out_ready`.
- Completion with a free slot: on the same edge, the output register loads the fill contents with the completing sample merged. Unwritten lanes are 0. `out_len` = frame length, `out_valid`=1. The fill register is cleared, `cnt`=0, and the state stays FILL.
- Completion with the slot occupied: the completing sample is written to the fill register, the frame length is latched, and the state goes to HOLD.
- HOLD exits on the output handshake (`out_valid && out_ready`). On that edge the output register loads the held frame, `out_valid` stays 1, the fill register is cleared, `cnt`=0, and the state returns to FILL.
- Output handshake with no pending frame: `out_valid` is 0 on the next cycle. `out_packed` holds its last value and is don't-care when `out_valid`=0.
- `in_last` is ignored unless the sample is accepted. `in_last` on lane LEN-1 is equivalent to a normal full frame.
- Samples are stored bit-exact; the block performs no arithmetic.
- Mid-frame reset discards the partial frame and any held or output frame.

## Timing
- Reset values: `in_ready`=0 during the reset cycle and 1 from the first cycle after reset deasserts. `out_valid`=0, `out_len`=0, `out_packed`=0, `cnt`=0, fill register=0, state=FILL.
- `in_ready` is a registered state decode. It does not combinationally depend on `out_ready`.
- Latency: the frame becomes visible (`out_valid`=1) in the cycle after the edge that accepts the completing sample, provided the slot is free.
- Throughput: with `out_ready` held at 1, one sample is accepted per cycle indefinitely, with no bubbles between frames.
- Backpressure: with `out_ready`=0, at most one complete frame plus one complete frame in HOLD are buffered. `in_ready` drops in the cycle after HOLD is entered.
- Simultaneous completion and output handshake in the same cycle counts as a free slot: the new frame replaces the consumed one with no gap.
- `out_packed` and `out_len` are stable while `out_valid && !out_ready`.

## Configuration
- `TREE_FEED_REVERSE_EN`: when defined, sample k of a frame lands in lane LEN-1-k. For short frames, the unwritten low lanes are zero. This matches tapped-delay-line ordering (newest sample in lane 0 after a full frame).
- When undefined, sample k lands in lane k.
- `out_len` semantics are identical in both builds.

## Test plan
Bench configuration: LEN=8, WIDTH=16.
- Reset, then feed 0x0001..0x0008 back-to-back with `out_ready`=1 → `out_valid` for 1 cycle, one cycle after the 8th accept. Lane k = k+1, `out_len`=8, `in_ready` never drops.
- Feed 3 samples 0xFFFF, 0x8000, 0x7FFF with `in_last` on the third → lanes 0..2 hold those values, lanes 3..7 = 0, `out_len`=3.
- Hold `out_ready`=0 and stream 0x0010..0x001F (two frames) → first frame held stable. `in_ready` falls after the 16th accept. Raising `out_ready` for 1 cycle swaps in the second frame with `out_valid` continuous, and `in_ready` returns to 1.
- Complete a frame in the same cycle as the output handshake of the previous frame → new frame appears next cycle, with no `out_valid` gap and no lost sample.
- Assert `reset` after 5 of 8 samples, then feed 0x00A0..0x00A7 → first `out_packed` is exactly 0x00A0..0x00A7 with no residue from the aborted frame.
- With `TREE_FEED_REVERSE_EN` defined, feed 0x0001..0x0008 → lane 7 = 0x0001, lane 0 = 0x0008. For a 3-sample short frame, lanes 7..5 are written and lanes 0..4 = 0.

Source files
------------

// File: rtl/tree_feed_deserializer_if.sv
// Stream bundle for tree_feed_deserializer.
//   Serial side : in_data, in_valid, in_last (producer -> block), in_ready (block -> producer)
//   Frame side  : out_packed, out_len, out_valid (block -> consumer), out_ready (consumer -> block)
// Modports: slave = the deserializer itself, master = the environment driving/consuming it.
interface tree_feed_deserializer_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LEN   = 1024
);
    localparam int unsigned LenW = $clog2(LEN) + 1;

    logic [WIDTH-1:0]     in_data;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;
    logic [LEN*WIDTH-1:0] out_packed;
    logic [LenW-1:0]      out_len;
    logic                 out_valid;
    logic                 out_ready;

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_packed, out_len, out_valid
    );

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_packed, out_len, out_valid
    );
endinterface

// File: rtl/tree_feed_deserializer.sv
// Serial-to-parallel front end for the pipelined adder tree.
// Collects LEN samples of WIDTH bits into one packed frame (lane k at [WIDTH*k +: WIDTH]) and
// presents it with valid/ready. A fill register and an output register let frames stream
// back-to-back; a short frame ended by in_last is zero-padded.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-high reset
//   bus_io - tree_feed_deserializer_if.slave (serial input side and packed frame output side)
// Build option: define TREE_FEED_REVERSE_EN to store sample k in lane LEN-1-k instead of lane k.
module tree_feed_deserializer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LEN   = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    tree_feed_deserializer_if.slave   bus_io
);
    localparam int unsigned CntW  = $clog2(LEN);
    localparam int unsigned LenW  = CntW + 1;
    localparam int unsigned DataW = LEN * WIDTH;

    typedef enum logic {StFill, StHold} state_e;

    state_e            state_q, state_d;
    logic [DataW-1:0]  fill_q, fill_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DataW-1:0]  out_q, out_d;
    logic [LenW-1:0]   out_len_q, out_len_d;
    logic              out_valid_q, out_valid_d;
    logic [LenW-1:0]   held_len_q, held_len_d;
    logic              in_ready_q, in_ready_d;

    logic [CntW-1:0]   lane;
    logic [DataW-1:0]  fill_merged;
    logic [LenW-1:0]   frame_len;
    logic              accept;
    logic              complete;
    logic              out_fire;
    logic              slot_free;

`ifdef TREE_FEED_REVERSE_EN
    assign lane = CntW'(LEN - 1) - cnt_q;
`else
    assign lane = cnt_q;
`endif

    assign accept    = bus_io.in_valid && in_ready_q;
    assign complete  = accept && ((cnt_q == CntW'(LEN - 1)) || bus_io.in_last);
    assign out_fire  = out_valid_q && bus_io.out_ready;
    assign slot_free = !out_valid_q || bus_io.out_ready;
    assign frame_len = LenW'(cnt_q) + LenW'(1);

    // Fill contents with the current sample already in place; used for both the normal write and
    // the direct load into the output register on completion.
    always_comb begin
        fill_merged = fill_q;
        fill_merged[int'(lane) * WIDTH +: WIDTH] = bus_io.in_data;
    end

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_len_d   = out_len_q;
        out_valid_d = out_valid_q;
        held_len_d  = held_len_q;

        // A consumed frame leaves the slot empty unless something below refills it.
        if (out_fire) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            StFill: begin
                if (complete && slot_free) begin
                    out_d       = fill_merged;
                    out_len_d   = frame_len;
                    out_valid_d = 1'b1;
                    fill_d      = '0;
                    cnt_d       = '0;
                end else if (complete) begin
                    fill_d     = fill_merged;
                    held_len_d = frame_len;
                    state_d    = StHold;
                end else if (accept) begin
                    fill_d = fill_merged;
                    cnt_d  = cnt_q + CntW'(1);
                end
            end
            StHold: begin
                if (out_fire) begin
                    out_d       = fill_q;
                    out_len_d   = held_len_q;
                    out_valid_d = 1'b1;
                    fill_d      = '0;
                    cnt_d       = '0;
                    state_d     = StFill;
                end
            end
            default: state_d = StFill;
        endcase

        // Registered decode of the next state keeps in_ready free of any out_ready path.
        in_ready_d = (state_d == StFill);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StFill;
            fill_q      <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            out_len_q   <= '0;
            out_valid_q <= 1'b0;
            held_len_q  <= '0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_len_q   <= out_len_d;
            out_valid_q <= out_valid_d;
            held_len_q  <= held_len_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus_io.in_ready   = in_ready_q;
    assign bus_io.out_packed = out_q;
    assign bus_io.out_len    = out_len_q;
    assign bus_io.out_valid  = out_valid_q;
endmodule

// File: tb/tb_tree_feed_deserializer.sv
// Self-checking bench for tree_feed_deserializer (LEN=8, WIDTH=16).
// A frame-level model (queue of completed frames awaiting consumption) is checked against the
// DUT on every falling edge; directed scenarios add literal expectations at key cycles.
module tb_tree_feed_deserializer;
    localparam int unsigned W     = 16;
    localparam int unsigned L     = 8;
    localparam int unsigned DataW = L * W;
    localparam int unsigned LenW  = $clog2(L) + 1;

    typedef struct {
        logic [DataW-1:0] data;
        int               len;
    } frame_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    tree_feed_deserializer_if #(.WIDTH(W), .LEN(L)) bus ();

    tree_feed_deserializer #(.WIDTH(W), .LEN(L)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DataW-1:0] act, input logic [DataW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    frame_t    pend[$];     // frames completed but not yet consumed, oldest is on the output
    logic [W-1:0] cur[$];   // samples of the frame being filled
    bit        started = 1'b0;
    bit        exp_rst = 1'b0;

    function automatic frame_t build_frame(input int n);
        frame_t f;
        f.data = '0;
        f.len  = n;
        for (int k = 0; k < n; k++) begin
`ifdef TREE_FEED_REVERSE_EN
            f.data[(L - 1 - k) * W +: W] = cur[k];
`else
            f.data[k * W +: W] = cur[k];
`endif
        end
        return f;
    endfunction

    always @(negedge clk) begin
        bit exp_ready;
        bit exp_valid;
        if (started) begin
            if (exp_rst) begin
                chk("rst_in_ready", DataW'(bus.in_ready), '0);
                chk("rst_out_valid", DataW'(bus.out_valid), '0);
                chk("rst_out_len", DataW'(bus.out_len), '0);
                chk("rst_out_packed", bus.out_packed, '0);
            end else begin
                chk("in_ready", DataW'(bus.in_ready), DataW'(pend.size() < 2));
                chk("out_valid", DataW'(bus.out_valid), DataW'(pend.size() > 0));
                if (pend.size() > 0) begin
                    chk("out_packed", bus.out_packed, pend[0].data);
                    chk("out_len", DataW'(bus.out_len), DataW'(pend[0].len));
                end
            end
        end
        // Advance the model across the coming rising edge.
        if (reset) begin
            pend.delete();
            cur.delete();
            exp_rst = 1'b1;
            started = 1'b1;
        end else if (started) begin
            exp_ready = !exp_rst && (pend.size() < 2);
            exp_valid = !exp_rst && (pend.size() > 0);
            if (exp_valid && bus.out_ready) void'(pend.pop_front());
            if (exp_ready && bus.in_valid) begin
                cur.push_back(bus.in_data);
                if (bus.in_last || cur.size() == L) begin
                    pend.push_back(build_frame(cur.size()));
                    cur.delete();
                end
            end
            exp_rst = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d, input bit last);
        bit acc;
        int n;
        n   = 0;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL push_timeout actual=in_ready_low required=accept data=%h", d);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Literal check of the visible frame on both DUT and model.
    task automatic chk_frame(input string name, input logic [DataW-1:0] exp, input int len);
        chk({name, "_valid"}, DataW'(bus.out_valid), DataW'(1));
        chk({name, "_data"}, bus.out_packed, exp);
        chk({name, "_len"}, DataW'(bus.out_len), DataW'(len));
        checks++;
        if (pend.size() == 0 || pend[0].data !== exp || pend[0].len != len) begin
            errors++;
            $display("FAIL %s_model actual=%0d_frames required=%h/%0d", name, pend.size(), exp, len);
        end
    endtask

    logic [DataW-1:0] e_seq, e_short, e_a, e_b, e_d, e_a0;

    initial begin
        checks = 0;
        errors = 0;
`ifdef TREE_FEED_REVERSE_EN
        e_seq   = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
        e_short = 128'hFFFF_8000_7FFF_0000_0000_0000_0000_0000;
        e_a     = 128'h0010_0011_0012_0013_0014_0015_0016_0017;
        e_b     = 128'h0018_0019_001A_001B_001C_001D_001E_001F;
        e_d     = 128'h0030_0031_0032_0033_0034_0035_0036_0037;
        e_a0    = 128'h00A0_00A1_00A2_00A3_00A4_00A5_00A6_00A7;
`else
        e_seq   = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
        e_short = 128'h0000_0000_0000_0000_0000_7FFF_8000_FFFF;
        e_a     = 128'h0017_0016_0015_0014_0013_0012_0011_0010;
        e_b     = 128'h001F_001E_001D_001C_001B_001A_0019_0018;
        e_d     = 128'h0037_0036_0035_0034_0033_0032_0031_0030;
        e_a0    = 128'h00A7_00A6_00A5_00A4_00A3_00A2_00A1_00A0;
`endif
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        chk("reset_in_ready", DataW'(bus.in_ready), '0);
        reset = 1'b0;
        step();
        chk("post_reset_in_ready", DataW'(bus.in_ready), DataW'(1));

        // Full frame streaming with the consumer always ready.
        for (int i = 1; i <= 8; i++) push(W'(i), 1'b0);
        chk_frame("full", e_seq, 8);
        step();
        chk("full_one_cycle", DataW'(bus.out_valid), '0);

        // Short frame with extreme signed values.
        push(16'hFFFF, 1'b0);
        push(16'h8000, 1'b0);
        push(16'h7FFF, 1'b1);
        chk_frame("short", e_short, 3);
        step();

        // Backpressure: two frames buffered, second one held.
        bus.out_ready = 1'b0;
        for (int i = 16; i < 32; i++) push(W'(i), 1'b0);
        chk("hold_in_ready", DataW'(bus.in_ready), '0);
        step();
        step();
        chk_frame("held_first", e_a, 8);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk_frame("swap_second", e_b, 8);
        chk("swap_in_ready", DataW'(bus.in_ready), DataW'(1));
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // Completion coinciding with consumption of the previous frame.
        for (int i = 32; i < 40; i++) push(W'(i), 1'b0);
        for (int i = 48; i < 55; i++) push(W'(i), 1'b0);
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h0037;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk_frame("overlap", e_d, 8);
        bus.out_ready = 1'b1;
        step();

        // Mid-frame reset leaves no residue.
        for (int i = 0; i < 5; i++) push(16'h0050 + W'(i), 1'b0);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) push(16'h00A0 + W'(i), 1'b0);
        chk_frame("after_reset", e_a0, 8);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end
endmodule
